// File: rtl/demux14_buf.sv
// 1-to-4 demultiplexer with a small FIFO per output channel.
// Words are routed by {is1,is0}; each channel drains independently via irdy.
module demux14_buf #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] id,
  input  logic          is1,
  input  logic          is0,
  input  logic          ivld,
  output logic          ordy,
  output logic [DW-1:0] oz0,
  output logic [DW-1:0] oz1,
  output logic [DW-1:0] oz2,
  output logic [DW-1:0] oz3,
  output logic [3:0]    ovld,
  input  logic [3:0]    irdy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [1:0]             sel;
  logic                   push;
  logic [3:0]             full;
  logic [3:0][DW-1:0]     head;

  assign sel  = {is1, is0};
  // Ready depends only on registered fullness and sel, never on irdy.
  assign ordy = ~full[sel];
  assign push = ivld & ordy;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  for (genvar n = 0; n < 4; n++) begin : g_ch
    localparam logic [1:0] CH = 2'(n);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic          push_n;
    logic          pop_n;

    assign push_n = push && (sel == CH);
    // A pop needs data already present, so a push into an empty channel never pops.
    assign pop_n  = (cnt != '0) && irdy[n];

    always_ff @(posedge clk) begin
      if (rst) begin
        rptr <= '0;
        wptr <= '0;
        cnt  <= '0;
      end else begin
        if (push_n) begin
          mem[wptr] <= id;
          wptr      <= bump(wptr);
        end
        if (pop_n) begin
          rptr <= bump(rptr);
        end
        case ({push_n, pop_n})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    assign full[n] = (cnt == FULL);
    assign ovld[n] = (cnt != '0);
    assign head[n] = (cnt != '0) ? mem[rptr] : '0;
  end

  assign oz0 = head[0];
  assign oz1 = head[1];
  assign oz2 = head[2];
  assign oz3 = head[3];

endmodule

// File: tb/tb_demux14_buf.sv
// Bench for demux14_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_demux14_buf;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] id = '0;
  logic          is1 = 1'b0;
  logic          is0 = 1'b0;
  logic          ivld = 1'b0;
  logic          ordy;
  logic [DW-1:0] oz [4];
  logic [3:0]    ovld;
  logic [3:0]    irdy = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit primed   = 1'b0;

  logic [DW-1:0] mq [4][$];

  demux14_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .id  (id),
    .is1 (is1),
    .is0 (is0),
    .ivld(ivld),
    .ordy(ordy),
    .oz0 (oz[0]),
    .oz1 (oz[1]),
    .oz2 (oz[2]),
    .oz3 (oz[3]),
    .ovld(ovld),
    .irdy(irdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, decisions taken on pre-edge state.
  always @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      primed = 1'b1;
    end else if (primed) begin
      int s;
      bit do_push;
      bit do_pop [4];
      s = {is1, is0};
      do_push = ivld && (mq[s].size() < DEPTH);
      for (int n = 0; n < 4; n++) do_pop[n] = (mq[n].size() > 0) && irdy[n];
      for (int n = 0; n < 4; n++) if (do_pop[n]) void'(mq[n].pop_front());
      if (do_push) mq[s].push_back(id);
    end
  end

  always @(negedge clk) begin
    if (primed) begin
      logic [3:0] ev;
      int s;
      s = {is1, is0};
      for (int n = 0; n < 4; n++) begin
        ev[n] = (mq[n].size() > 0);
        check($sformatf("model_oz%0d", n), 32'(oz[n]), ev[n] ? 32'(mq[n][0]) : 32'd0);
      end
      check("model_ovld", 32'(ovld), 32'(ev));
      check("model_ordy", 32'(ordy), (mq[s].size() < DEPTH) ? 32'd1 : 32'd0);
    end
  end

  task automatic set_sel(input logic [1:0] s);
    is1 = s[1];
    is0 = s[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [1:0] s);
    ivld = 1'b1;
    id   = d;
    set_sel(s);
    tick();
    ivld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with a valid word offered.
    rst = 1'b1; ivld = 1'b1; id = 4'hf; set_sel(2'b00);
    repeat (2) tick();
    rst = 1'b0; ivld = 1'b0;
    check("rst_ovld", 32'(ovld), 32'h0);
    for (int n = 0; n < 4; n++) check($sformatf("rst_oz%0d", n), 32'(oz[n]), 32'h0);
    check("rst_ordy", 32'(ordy), 32'h1);

    // Routing, first push right after reset release.
    push_word(4'h1, 2'b00);
    push_word(4'h2, 2'b01);
    push_word(4'h3, 2'b10);
    push_word(4'h4, 2'b11);
    check("route_oz0", 32'(oz[0]), 32'h1);
    check("route_oz1", 32'(oz[1]), 32'h2);
    check("route_oz2", 32'(oz[2]), 32'h3);
    check("route_oz3", 32'(oz[3]), 32'h4);
    check("route_ovld", 32'(ovld), 32'hf);
    irdy = 4'hf; tick(); irdy = '0;
    check("drain_all_ovld", 32'(ovld), 32'h0);

    // Full and backpressure on ch2.
    push_word(4'h5, 2'b10);
    push_word(4'h6, 2'b10);
    ivld = 1'b1; id = 4'h7; set_sel(2'b10);
    #1 check("full_ordy", 32'(ordy), 32'h0);
    tick();
    check("held_oz2", 32'(oz[2]), 32'h5);
    irdy[2] = 1'b1; tick(); irdy[2] = 1'b0;
    check("bp_pop_oz2", 32'(oz[2]), 32'h6);
    check("bp_ordy", 32'(ordy), 32'h1);
    tick(); ivld = 1'b0;
    check("bp_accept_oz2", 32'(oz[2]), 32'h6);
    check("bp_refull_ordy", 32'(ordy), 32'h0);
    irdy[2] = 1'b1; tick();
    check("bp_next_oz2", 32'(oz[2]), 32'h7);
    tick(); irdy[2] = 1'b0;
    check("bp_empty_ovld", 32'(ovld), 32'h0);

    // Simultaneous push/pop on ch0 holding one entry.
    push_word(4'h9, 2'b00);
    ivld = 1'b1; id = 4'h8; set_sel(2'b00); irdy[0] = 1'b1;
    tick(); ivld = 1'b0;
    check("pp_oz0", 32'(oz[0]), 32'h8);
    check("pp_ovld", 32'(ovld), 32'h1);
    tick(); irdy[0] = 1'b0;
    check("pp_drained", 32'(ovld), 32'h0);

    // Push into empty ch1 with irdy[1] high: the word must not be popped.
    irdy[1] = 1'b1;
    push_word(4'ha, 2'b01);
    check("empty_push_oz1", 32'(oz[1]), 32'ha);
    check("empty_push_ovld", 32'(ovld), 32'h2);
    tick(); irdy[1] = 1'b0;
    check("empty_push_pop", 32'(ovld), 32'h0);

    // Continuous stream through ch3 across pointer wraps.
    irdy[3] = 1'b1; ivld = 1'b1; set_sel(2'b11);
    for (int i = 0; i < 10; i++) begin
      id = 4'(i);
      tick();
      check($sformatf("wrap_oz3_%0d", i), 32'(oz[3]), 32'(i));
      check($sformatf("wrap_vld_%0d", i), 32'(ovld[3]), 32'h1);
    end
    ivld = 1'b0; tick(); irdy[3] = 1'b0;
    check("wrap_end_ovld", 32'(ovld), 32'h0);

    // Reset mid-operation with a word offered in the reset cycle.
    push_word(4'hb, 2'b01);
    push_word(4'hc, 2'b01);
    rst = 1'b1; ivld = 1'b1; id = 4'hd; set_sel(2'b01);
    tick();
    rst = 1'b0; ivld = 1'b0;
    check("midrst_ovld", 32'(ovld), 32'h0);
    check("midrst_oz1", 32'(oz[1]), 32'h0);
    tick();
    check("midrst_nostore", 32'(ovld), 32'h0);

    // Mixed traffic, checked against the model on every cycle.
    for (int i = 0; i < 400; i++) begin
      ivld = 1'($urandom_range(0, 1));
      id   = 4'($urandom);
      set_sel(2'($urandom));
      irdy = 4'($urandom) & 4'($urandom);
      tick();
    end
    ivld = 1'b0; irdy = 4'hf;
    repeat (DEPTH + 1) tick();
    check("final_ovld", 32'(ovld), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux14_buf.md
DEMUX14_BUF -- requirements
Module: demux14_buf

Interface
REQ-001 Parameter DW, default 4, data width of the input word and of every output channel.
REQ-002 Parameter DEPTH, default 2, number of entries in each per-channel FIFO; legal values 1..8.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 id  input  DW  data word to be routed.
REQ-007 is1  input  1  channel select, MSB.
REQ-008 is0  input  1  channel select, LSB.
REQ-009 ivld  input  1  upstream asserts that id, is1 and is0 are valid.
REQ-010 ordy  output  1  block can accept the offered word this cycle.
REQ-011 oz0..oz3  output  DW each  head-of-FIFO data for channels 0..3.
REQ-012 ovld  output  4  bit n set means channel n holds data.
REQ-013 irdy  input  4  bit n set means the downstream consumer takes channel n this cycle.

Function
REQ-014 The block SHALL decode sel = {is1,is0}, mapping 00->ch0, 01->ch1, 10->ch2 and 11->ch3, as the inverse of the 4:1 selector.
REQ-015 ordy SHALL equal NOT full[sel], computed combinationally from registered state and sel only, with no combinational path from irdy.
REQ-016 A push SHALL occur on a rising edge where ivld=1 and ordy=1, writing id into the FIFO of channel sel.
REQ-017 When ivld=1 and ordy=0, no state SHALL change, and upstream holds id/sel.
REQ-018 ovld[n] SHALL be 1 when count[n] is greater than 0, as a registered-state function.
REQ-019 ozn SHALL present the oldest entry of channel n when ovld[n]=1, and 0 when it is empty.
REQ-020 A pop on channel n SHALL occur on a rising edge where ovld[n]=1 and irdy[n]=1; irdy[n] with ovld[n]=0 is ignored.
REQ-021 Latency: a word pushed at edge k SHALL appear on ozn with ovld[n]=1 after edge k, i.e. one cycle, when the channel was empty.
REQ-022 Each channel SHALL be FIFO-ordered; there is no ordering guarantee across channels.
REQ-023 count[n] SHALL range 0..DEPTH: push only gives +1, pop only gives -1, push and pop in the same cycle leave it unchanged.
REQ-024 Full boundary: with count[sel]=DEPTH, ordy SHALL be 0 even if irdy[sel]=1 in the same cycle, and the push is refused.
REQ-025 Empty boundary: pushing into an empty channel while irdy[n]=1 SHALL NOT pop in the same cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH with no loss or duplication across the wrap.
REQ-027 Pops on several channels SHALL be independent and MAY all occur in one cycle alongside one push.
REQ-028 The block SHALL never drop, duplicate or reorder an accepted word.

Reset
REQ-029 While rst=1 at a rising edge, all counts and pointers SHALL clear to 0, ovld SHALL be 0000, oz0..oz3 SHALL be 0, and ordy SHALL be 1 from the next cycle.
REQ-030 rst SHALL take priority over a simultaneous push or pop, and in-flight FIFO contents SHALL be discarded.
REQ-031 After rst deasserts, the first valid push SHALL be accepted on the first edge with no idle cycle required.

Verification
REQ-032 Reset: assert rst for 2 cycles with ivld=1 -> ovld=0000, oz0..oz3=0, ordy=1 after release, no data stored.
REQ-033 Routing: push 0001/sel00, 0010/sel01, 0011/sel10, 0100/sel11 with irdy=0000 -> oz0=0001, oz1=0010, oz2=0011, oz3=0100, ovld=1111.
REQ-034 Full/backpressure: DEPTH=2, irdy=0, push 0101 then 0110 to ch2 -> ordy=0 for sel=10; a third push of 0111 is held; assert irdy[2] for 1 cycle -> oz2 moves to 0110; next edge accepts 0111.
REQ-035 Simultaneous push/pop: ch0 holds 1 entry, push 1000 to ch0 with irdy[0]=1 -> count stays 1, oz0=1000 next cycle.
REQ-036 Wrap: stream 10 words 0000..1001 to ch3 with irdy[3]=1 continuous -> all 10 values appear on oz3 in order, with no gaps once primed.
REQ-037 Reset mid-operation: fill ch1 with 2 entries, then pulse rst together with ivld=1 -> ovld=0000 and the entry offered in the reset cycle is not stored.
